layer_window_loader: RTL
========================

// Module: layer_window_loader
// PURPOSE
//  Responder side of the per-layer buffer-load handshake driven by the network controller.
//  Accepts initLd/ldBuf, walks a KxK window over a row-major feature map in memory,
//  writes the window into the PE input buffer and returns ldBufDone/ctrlDone.
//  Also owns the result write address, advanced on each memWrEn from the controller.
//  One instance per layer (L1, L2).
// PARAMETERS
//  IMG_W   8  feature-map width (pixels)
//  IMG_H   8  feature-map height (pixels)
//  K       3  window/kernel size
//  STRIDE  1  window step, both directions
//  DATA_W  8  pixel width
//  ADDR_W  6  read/write address width; IMG_W*IMG_H <= 2**ADDR_W
//  Derived: OUT_W=(IMG_W-K)/STRIDE+1, OUT_H=(IMG_H-K)/STRIDE+1
// PORTS
//  clk        in   1       clock
//  rst        in   1       async reset, active high
//  initLd     in   1       start layer: window to (0,0), full load
//  ldBuf      in   1       advance window one step, then load
//  memWrEn    in   1       result stored this cycle; advances wrAddr
//  rdAddr     out  ADDR_W  feature-memory read address
//  rdData     in   DATA_W  read data, valid 1 cycle after rdAddr
//  bufWrEn    out  1       buffer write strobe
//  bufRow     out  clog2(K) buffer row index i
//  bufCol     out  clog2(K) buffer column index j
//  bufData    out  DATA_W  buffer write data (= rdData)
//  bufShift   out  1       shift buffer one column left (SLIDE_REUSE_EN only; else tied 0)
//  ldBufDone  out  1       one-cycle pulse: window fully written
//  ctrlDone   out  1       level: current window is the last window of the layer
//  wrAddr     out  ADDR_W  result write address (output index)
// BEHAVIOUR
//  Reset: all outputs 0; origin (r0,c0)=(0,0); wrAddr=0; FSM IDLE.
//  FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//   IDLE: initLd -> origin (0,0), ISSUE. ldBuf & !ctrlDone -> step origin, ISSUE.
//     Step: c0+=STRIDE; if c0 was (OUT_W-1)*STRIDE then c0=0, r0+=STRIDE.
//     ldBuf while ctrlDone: ignored, no ldBufDone.
//   ISSUE: one read per cycle, i outer, j inner, 0..K-1;
//     rdAddr=(r0+i)*IMG_W+(c0+j). After last read -> DRAIN.
//   Write side: bufWrEn/bufRow/bufCol registered one cycle behind rdAddr, bufData=rdData.
//   DRAIN: final write. DONE: ldBufDone=1 for exactly one cycle.
//  Latency: request sampled at edge 0 -> reads cycles 1..K*K, writes 2..K*K+1,
//   ldBufDone in cycle K*K+2 (11 at defaults).
//  ctrlDone = (r0==(OUT_H-1)*STRIDE && c0==(OUT_W-1)*STRIDE), from origin regs;
//   valid from ISSUE of the last window until next initLd/rst.
//  wrAddr: +1 at each edge with memWrEn=1; cleared by initLd; no wrap check
//   (controller issues exactly OUT_W*OUT_H writes).
//  Busy (not IDLE): ldBuf ignored; initLd aborts current load, restarts at (0,0),
//   no ldBufDone for the aborted load.
//  memWrEn concurrent with initLd/ldBuf: initLd clear wins; with ldBuf both take effect.
//  rst mid-load: immediate return to reset state, no ldBufDone.
// CONFIGURATION
//  SLIDE_REUSE_EN defined: a horizontal step (no row wrap) pulses bufShift in its first
//   ISSUE cycle and reads only column j=K-1, i=0..K-1; ldBufDone in cycle K+2.
//   initLd and row wraps still do full K*K loads.
//  Undefined: every load is full K*K; bufShift constant 0.
// TESTING (defaults, 6x6=36 windows)
//  rst, initLd -> rdAddr 0,1,2,8,9,10,16,17,18 cycles 1-9; one ldBufDone cycle 11; ctrlDone=0.
//  Next ldBuf -> origin (0,1), rdAddr 1,2,3,9,10,11,17,18,19; ldBufDone 11 cycles later.
//  ldBuf from (0,5) -> wrap to (1,0), rdAddr 8,9,10,16,17,18,24,25,26.
//  Load all 36 windows -> ctrlDone=1 at (5,5); extra ldBuf gives no reads, no ldBufDone.
//  36 memWrEn pulses, one coinciding with ldBuf -> wrAddr 0..36, window still loaded.
//  rst in cycle 5 of a load -> outputs 0, no ldBufDone; SLIDE_REUSE_EN: (0,0)->(0,1)
//   gives bufShift, rdAddr 3,11,19, ldBufDone cycle 5.

Source files
------------

// File: rtl/layer_window_loader_if.sv
// Buffer-load handshake between the network controller (master) and a
// per-layer window loader (slave), plus the feature-memory read port and
// the PE input-buffer write port.
interface layer_window_loader_if #(
  parameter int K      = 3,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  // controller -> loader
  logic              initLd;
  logic              ldBuf;
  logic              memWrEn;
  // feature memory -> loader
  logic [DATA_W-1:0] rdData;
  // loader -> memory / buffer / controller
  logic [ADDR_W-1:0] rdAddr;
  logic              bufWrEn;
  logic [IDX_W-1:0]  bufRow;
  logic [IDX_W-1:0]  bufCol;
  logic [DATA_W-1:0] bufData;
  logic              bufShift;
  logic              ldBufDone;
  logic              ctrlDone;
  logic [ADDR_W-1:0] wrAddr;

  modport master (
    output initLd, ldBuf, memWrEn, rdData,
    input  rdAddr, bufWrEn, bufRow, bufCol, bufData, bufShift,
           ldBufDone, ctrlDone, wrAddr
  );

  modport slave (
    input  initLd, ldBuf, memWrEn, rdData,
    output rdAddr, bufWrEn, bufRow, bufCol, bufData, bufShift,
           ldBufDone, ctrlDone, wrAddr
  );
endinterface

// File: rtl/layer_window_loader.sv
// Per-layer window loader: walks a KxK window over a row-major feature map and writes it into the PE buffer.
// Latency: request at edge 0 -> reads cycles 1..K*K, buffer writes 2..K*K+1, ldBufDone pulse in cycle K*K+2.
// Backpressure: none; ldBuf is ignored while busy or on the last window, initLd aborts and restarts.
//
// Ports: clk, rst (async, active high); bus (slave modport of layer_window_loader_if):
//   initLd/ldBuf/memWrEn in  - start layer / advance window / result stored
//   rdAddr out, rdData in    - feature-memory read, data one cycle after address
//   bufWrEn/bufRow/bufCol/bufData out - buffer write port; bufShift out - shift buffer left
//   ldBufDone out (pulse), ctrlDone out (level, last window), wrAddr out (result address)
// Optional feature macro: SLIDE_REUSE_EN - horizontal steps shift the buffer and
//   fetch only the new right-hand column (K reads instead of K*K).
module layer_window_loader #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  layer_window_loader_if.slave   bus
);

  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  localparam logic [ADDR_W-1:0] LAST_C   = ADDR_W'((OUT_W - 1) * STRIDE);
  localparam logic [ADDR_W-1:0] LAST_R   = ADDR_W'((OUT_H - 1) * STRIDE);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [IDX_W-1:0]  KM1      = IDX_W'(K - 1);

`ifdef SLIDE_REUSE_EN
  localparam bit SLIDE_EN = 1'b1;
`else
  localparam bit SLIDE_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] r0_q, r0_d;
  logic [ADDR_W-1:0] c0_q, c0_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [IDX_W-1:0]  j_q, j_d;
  logic              slide_q, slide_d;   // current load fetches only column K-1
  logic              shift_q, shift_d;   // first ISSUE cycle of a sliding load
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              buf_wr_en_q, buf_wr_en_d;
  logic [IDX_W-1:0]  buf_row_q, buf_row_d;
  logic [IDX_W-1:0]  buf_col_q, buf_col_d;

  logic              ctrl_done;
  logic              last_rd;
  logic [ADDR_W-1:0] rd_row;
  logic [ADDR_W-1:0] rd_addr;

  assign ctrl_done = (r0_q == LAST_R) && (c0_q == LAST_C);
  assign last_rd   = (i_q == KM1) && (j_q == KM1);
  assign rd_row    = r0_q + ADDR_W'(i_q);
  assign rd_addr   = rd_row * IMG_W_A + c0_q + ADDR_W'(j_q);

  always_comb begin
    state_d     = state_q;
    r0_d        = r0_q;
    c0_d        = c0_q;
    i_d         = i_q;
    j_d         = j_q;
    slide_d     = slide_q;
    shift_d     = shift_q;
    wr_addr_d   = bus.memWrEn ? wr_addr_q + 1'b1 : wr_addr_q;
    // A read issued in the cycle initLd arrives belongs to the aborted load; drop its write.
    buf_wr_en_d = (state_q == S_ISSUE) && !bus.initLd;
    buf_row_d   = i_q;
    buf_col_d   = j_q;

    if (bus.initLd) begin
      // initLd wins over everything, including a concurrent memWrEn.
      state_d   = S_ISSUE;
      r0_d      = '0;
      c0_d      = '0;
      i_d       = '0;
      j_d       = '0;
      slide_d   = 1'b0;
      shift_d   = 1'b0;
      wr_addr_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ldBuf && !ctrl_done) begin
            state_d = S_ISSUE;
            i_d     = '0;
            if (c0_q == LAST_C) begin
              // Row wrap always needs a full reload.
              c0_d    = '0;
              r0_d    = r0_q + STRIDE_A;
              j_d     = '0;
              slide_d = 1'b0;
              shift_d = 1'b0;
            end else begin
              c0_d    = c0_q + STRIDE_A;
              j_d     = SLIDE_EN ? KM1 : '0;
              slide_d = SLIDE_EN;
              shift_d = SLIDE_EN;
            end
          end
        end
        S_ISSUE: begin
          shift_d = 1'b0;
          if (last_rd) begin
            state_d = S_DRAIN;
          end else if (j_q == KM1) begin
            i_d = i_q + 1'b1;
            j_d = slide_q ? KM1 : '0;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
        S_DRAIN: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      r0_q        <= '0;
      c0_q        <= '0;
      i_q         <= '0;
      j_q         <= '0;
      slide_q     <= 1'b0;
      shift_q     <= 1'b0;
      wr_addr_q   <= '0;
      buf_wr_en_q <= 1'b0;
      buf_row_q   <= '0;
      buf_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      r0_q        <= r0_d;
      c0_q        <= c0_d;
      i_q         <= i_d;
      j_q         <= j_d;
      slide_q     <= slide_d;
      shift_q     <= shift_d;
      wr_addr_q   <= wr_addr_d;
      buf_wr_en_q <= buf_wr_en_d;
      buf_row_q   <= buf_row_d;
      buf_col_q   <= buf_col_d;
    end
  end

  assign bus.rdAddr    = (state_q == S_ISSUE) ? rd_addr : '0;
  assign bus.bufWrEn   = buf_wr_en_q;
  assign bus.bufRow    = buf_row_q;
  assign bus.bufCol    = buf_col_q;
  assign bus.bufData   = buf_wr_en_q ? bus.rdData : {DATA_W{1'b0}};
  assign bus.bufShift  = SLIDE_EN & shift_q & (state_q == S_ISSUE);
  assign bus.ldBufDone = (state_q == S_DONE);
  assign bus.ctrlDone  = ctrl_done;
  assign bus.wrAddr    = wr_addr_q;

endmodule
